lc3_mem_access: RTL and testbench

- Data-memory access stage directly downstream of the pipeline controller.
- Consumes the controller's 2-bit mem_state plus the execute-stage address and store value.
- Runs a req/ack handshake with a variable-latency data memory and returns complete_data to the controller.
- Holds the indirect pointer for LDI/STI and presents load data (memout) to writeback.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/lc3_mem_timeout.sv | 31 +++
 rtl/lc3_mem_access.sv | 127 ++++++++++++
 tb/tb_lc3_mem_access.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Types and constants shared by the LC-3 pipeline controller and the data-memory access stage.
package lc3_pkg;

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_cmd_t;

  typedef enum logic [1:0] {
    MACC_IDLE = 2'd0,
    MACC_WAIT = 2'd1,
    MACC_DONE = 2'd2
  } macc_state_t;

  // Value returned to writeback when a load is aborted by timeout.
  localparam logic [15:0] BUS_ERR_DATA = 16'h0000;

endpackage

// File: rtl/lc3_mem_timeout.sv
// Saturating wait-cycle counter; expired is high once the count reaches TIMEOUT_CYCLES-1.
module lc3_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 data-memory access stage: req/ack handshake with variable-latency memory,
// indirect pointer holding for LDI/STI, and timeout abort with bus_error.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mem_state,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              complete_data,
  output logic [DATA_W-1:0] memout,
  output logic              bus_error
);

  macc_state_t       state, next_state;
  mem_cmd_t          cmd_in, cmd_q;
  logic [ADDR_W-1:0] ptr_reg;
  logic              ind_pend;
  logic              issue, ack_done, timed_out, expired, use_ptr;

  assign cmd_in  = mem_cmd_t'(mem_state);
  assign use_ptr = ind_pend && ((cmd_in == MEM_RD) || (cmd_in == MEM_WR));

  lc3_mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != MACC_WAIT),
    .enable  (state == MACC_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MACC_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    ack_done   = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      MACC_IDLE: begin
        if (cmd_in != MEM_IDLE) begin
          issue      = 1'b1;
          next_state = MACC_WAIT;
        end
      end
      MACC_WAIT: begin
        // An ack in the final allowed cycle still wins over the abort.
        if (dmem_ack) begin
          ack_done   = 1'b1;
          next_state = MACC_DONE;
        end else if (expired) begin
          timed_out  = 1'b1;
          next_state = MACC_DONE;
        end
      end
      MACC_DONE: next_state = MACC_IDLE;
      default:   next_state = MACC_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      complete_data <= 1'b0;
      bus_error     <= 1'b0;
      memout        <= '0;
      ptr_reg       <= '0;
      ind_pend      <= 1'b0;
      cmd_q         <= MEM_IDLE;
    end else begin
      complete_data <= ack_done | timed_out;
      bus_error     <= timed_out;

      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= (cmd_in == MEM_WR);
        dmem_addr  <= use_ptr ? ptr_reg : M_Addr;
        dmem_wdata <= M_Data;
        cmd_q      <= cmd_in;
      end

      if (ack_done || timed_out) dmem_req <= 1'b0;

      // The command captured at issue decides the result, not the live mem_state.
      if (ack_done) begin
        unique case (cmd_q)
          MEM_IND: begin
            ptr_reg  <= ADDR_W'(dmem_rdata);
            ind_pend <= 1'b1;
          end
          MEM_RD: begin
            memout   <= dmem_rdata;
            ind_pend <= 1'b0;
          end
          default: ind_pend <= 1'b0;
        endcase
      end

      if (timed_out) begin
        ind_pend <= 1'b0;
        memout   <= DATA_W'(BUS_ERR_DATA);
      end

      if ((state == MACC_IDLE) && (cmd_in == MEM_IDLE)) ind_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access: reads, stores, LDI/STI, timeout, stray acks, async reset.
module tb_lc3_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mem_state;
  logic [15:0] M_Addr, M_Data, dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, complete_data, bus_error;
  logic [15:0] dmem_addr, dmem_wdata, memout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lc3_mem_access #(.TIMEOUT_CYCLES(16), .ADDR_W(16), .DATA_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_state     (mem_state),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .complete_data (complete_data),
    .memout        (memout),
    .bus_error     (bus_error)
  );

  // Runs one access starting from IDLE. ack_at is the WAIT-cycle index in which
  // the memory acks (-1 = never). Returns just after the cycle following DONE.
  // During WAIT mem_state is forced to idle to show the captured command is used.
  task automatic run_access(input logic [1:0] cmd, input logic [15:0] addr, input logic [15:0] wdata,
                            input int ack_at, input logic [15:0] rdata,
                            output int req_cyc, output int cd_edge, output int cd_count,
                            output int be_count, output logic [15:0] seen_addr,
                            output logic seen_we, output logic [15:0] seen_wdata,
                            output logic stable);
    int n;
    bit seen;
    req_cyc = 0; cd_edge = -1; cd_count = 0; be_count = 0;
    seen_addr = 'x; seen_we = 1'bx; seen_wdata = 'x; stable = 1'b1; seen = 1'b0;
    mem_state = cmd; M_Addr = addr; M_Data = wdata; dmem_ack = 1'b0; dmem_rdata = rdata;
    n = 0;
    while (n < 40) begin
      @(posedge clock); n++; #1;
      if (dmem_req) begin
        req_cyc++;
        if (!seen) begin
          seen = 1'b1; seen_addr = dmem_addr; seen_we = dmem_we; seen_wdata = dmem_wdata;
        end else if (dmem_addr !== seen_addr || dmem_we !== seen_we || dmem_wdata !== seen_wdata) begin
          stable = 1'b0;
        end
      end
      if (complete_data) cd_count++;
      if (bus_error) be_count++;
      if (n == 1) mem_state = 2'd3;
      dmem_ack = (dmem_req && (n - 1 == ack_at));
      if (cd_edge >= 0) break;
      if (complete_data) cd_edge = n;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_state = 2'd3; M_Addr = 16'h0; M_Data = 16'h0;
    dmem_rdata = 16'h0; dmem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    if ({dmem_req, dmem_we, complete_data, bus_error} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {dmem_req, dmem_we, complete_data, bus_error});
    end
    total++;
    if ({dmem_addr, dmem_wdata, memout} !== 48'h0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", dmem_addr, dmem_wdata, memout);
    end
    total++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_read;
    int rc, ce, cc, bc; logic [15:0] a, wd; logic we, st;
    run_access(2'd0, 16'h3010, 16'h0, 2, 16'hBEEF, rc, ce, cc, bc, a, we, wd, st);
    if (rc !== 3 || a !== 16'h3010 || we !== 1'b0 || !st) begin
      bad++; $display("FAIL read_req: cycles=%0d addr=%h we=%b stable=%b want 3/3010/0/1", rc, a, we, st);
    end
    total++;
    if (cc !== 1 || ce !== 4 || bc !== 0) begin
      bad++; $display("FAIL read_done: pulses=%0d edge=%0d err=%0d want 1/4/0", cc, ce, bc);
    end
    total++;
    if (memout !== 16'hBEEF) begin
      bad++; $display("FAIL read_memout: got %h want beef", memout);
    end
    total++;
  endtask

  task automatic test_store;
    int rc, ce, cc, bc; logic [15:0] a, wd; logic we, st;
    run_access(2'd2, 16'h4000, 16'h1234, 0, 16'hDEAD, rc, ce, cc, bc, a, we, wd, st);
    if (a !== 16'h4000 || we !== 1'b1 || wd !== 16'h1234 || rc !== 1) begin
      bad++; $display("FAIL store_req: addr=%h we=%b wdata=%h cycles=%0d want 4000/1/1234/1", a, we, wd, rc);
    end
    total++;
    if (cc !== 1 || ce !== 2 || memout !== 16'hBEEF) begin
      bad++; $display("FAIL store_done: pulses=%0d edge=%0d memout=%h want 1/2/beef", cc, ce, memout);
    end
    total++;
  endtask

  task automatic test_ldi;
    int rc, ce, cc, bc, pulses; logic [15:0] a, wd; logic we, st;
    run_access(2'd1, 16'h3000, 16'h0, 0, 16'h5000, rc, ce, cc, bc, a, we, wd, st);
    pulses = cc;
    if (a !== 16'h3000 || we !== 1'b0 || memout !== 16'hBEEF) begin
      bad++; $display("FAIL ldi_ptr: addr=%h we=%b memout=%h want 3000/0/beef", a, we, memout);
    end
    total++;
    run_access(2'd0, 16'h1111, 16'h0, 1, 16'hCAFE, rc, ce, cc, bc, a, we, wd, st);
    pulses += cc;
    if (a !== 16'h5000 || memout !== 16'hCAFE || pulses !== 2) begin
      bad++; $display("FAIL ldi_data: addr=%h memout=%h pulses=%0d want 5000/cafe/2", a, memout, pulses);
    end
    total++;
  endtask

  task automatic test_sti;
    int rc, ce, cc, bc; logic [15:0] a, wd; logic we, st;
    run_access(2'd1, 16'h3004, 16'h0, 0, 16'h6000, rc, ce, cc, bc, a, we, wd, st);
    run_access(2'd2, 16'h1234, 16'hA5A5, 0, 16'h0, rc, ce, cc, bc, a, we, wd, st);
    if (a !== 16'h6000 || we !== 1'b1 || wd !== 16'hA5A5 || memout !== 16'hCAFE) begin
      bad++; $display("FAIL sti_write: addr=%h we=%b wdata=%h memout=%h want 6000/1/a5a5/cafe", a, we, wd, memout);
    end
    total++;
  endtask

  task automatic test_ind_cleared_by_idle;
    int rc, ce, cc, bc; logic [15:0] a, wd; logic we, st;
    run_access(2'd1, 16'h3008, 16'h0, 0, 16'h7777, rc, ce, cc, bc, a, we, wd, st);
    repeat (2) @(posedge clock);
    #1;
    run_access(2'd0, 16'h4444, 16'h0, 0, 16'h2468, rc, ce, cc, bc, a, we, wd, st);
    if (a !== 16'h4444 || memout !== 16'h2468) begin
      bad++; $display("FAIL idle_clears_ptr: addr=%h memout=%h want 4444/2468", a, memout);
    end
    total++;
  endtask

  task automatic test_timeout;
    int rc, ce, cc, bc; logic [15:0] a, wd; logic we, st;
    run_access(2'd0, 16'h3020, 16'h0, -1, 16'hFFFF, rc, ce, cc, bc, a, we, wd, st);
    if (rc !== 16 || a !== 16'h3020 || !st) begin
      bad++; $display("FAIL timeout_req: cycles=%0d addr=%h stable=%b want 16/3020/1", rc, a, st);
    end
    total++;
    if (cc !== 1 || bc !== 1 || ce !== 17) begin
      bad++; $display("FAIL timeout_done: pulses=%0d err=%0d edge=%0d want 1/1/17", cc, bc, ce);
    end
    total++;
    if (memout !== 16'h0000) begin
      bad++; $display("FAIL timeout_memout: got %h want 0000", memout);
    end
    total++;
  endtask

  task automatic test_stray_ack;
    int early_done;
    early_done = 0;
    mem_state = 2'd3; dmem_ack = 1'b1; dmem_rdata = 16'h9999;
    @(posedge clock); #1;
    if (complete_data !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL stray_ack_idle: complete=%b req=%b want 0/0", complete_data, dmem_req);
    end
    total++;
    mem_state = 2'd0; M_Addr = 16'h5555;
    @(posedge clock); #1;
    dmem_ack = 1'b0; mem_state = 2'd3;
    repeat (2) begin
      @(posedge clock); #1;
      if (complete_data || !dmem_req) early_done++;
    end
    if (early_done !== 0) begin
      bad++; $display("FAIL issue_ack_ignored: early events=%0d want 0", early_done);
    end
    total++;
    dmem_ack = 1'b1; dmem_rdata = 16'h0F0F;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    if (complete_data !== 1'b1 || dmem_req !== 1'b0 || memout !== 16'h0F0F || bus_error !== 1'b0) begin
      bad++; $display("FAIL late_ack_done: complete=%b req=%b memout=%h err=%b want 1/0/0f0f/0",
                      complete_data, dmem_req, memout, bus_error);
    end
    total++;
    dmem_ack = 1'b1;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    if (complete_data !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL stray_ack_done: complete=%b req=%b want 0/0", complete_data, dmem_req);
    end
    total++;
  endtask

  task automatic test_reset_mid_wait;
    int rc, ce, cc, bc, stray; logic [15:0] a, wd; logic we, st;
    run_access(2'd1, 16'h3100, 16'h0, 0, 16'h7000, rc, ce, cc, bc, a, we, wd, st);
    mem_state = 2'd0; M_Addr = 16'h2000;
    @(posedge clock); #1;
    mem_state = 2'd3;
    if (dmem_req !== 1'b1 || dmem_addr !== 16'h7000) begin
      bad++; $display("FAIL pre_reset_ptr: req=%b addr=%h want 1/7000", dmem_req, dmem_addr);
    end
    total++;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    if (dmem_req !== 1'b0 || complete_data !== 1'b0 || memout !== 16'h0) begin
      bad++; $display("FAIL async_reset: req=%b complete=%b memout=%h want 0/0/0", dmem_req, complete_data, memout);
    end
    total++;
    @(posedge clock); #1;
    reset = 1'b0;
    stray = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (complete_data || dmem_req) stray++;
    end
    if (stray !== 0) begin
      bad++; $display("FAIL post_reset_quiet: events=%0d want 0", stray);
    end
    total++;
    run_access(2'd0, 16'h2222, 16'h0, 0, 16'h1357, rc, ce, cc, bc, a, we, wd, st);
    if (a !== 16'h2222 || memout !== 16'h1357 || cc !== 1) begin
      bad++; $display("FAIL post_reset_read: addr=%h memout=%h pulses=%0d want 2222/1357/1", a, memout, cc);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_store();
    test_ldi();
    test_sti();
    test_ind_cleared_by_idle();
    test_timeout();
    test_stray_ack();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
